// File: rtl/vga_sync_decoder.sv
// VGA timing receiver: recovers pixel position and data-enable from hsync/vsync/blank,
// locks onto the sync stream and flags edges or blanking that disagree with nominal timing.
module vga_sync_decoder #(
   parameter int H_TOTAL      = 1344,
   parameter int H_ACTIVE     = 1024,
   parameter int H_SYNC_START = 1048,
   parameter int H_SYNC_LEN   = 136,
   parameter int V_TOTAL      = 806,
   parameter int V_ACTIVE     = 768,
   parameter int V_SYNC_START = 771,
   parameter int V_SYNC_LEN   = 6,
   parameter bit SYNC_POL     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        de,
   output logic        locked,
   output logic        frame_start,
   output logic        err_hsync,
   output logic        err_vsync,
   output logic        err_blank,
   output logic [7:0]  err_count
);

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
   localparam logic [10:0] HS_ON  = 11'(H_SYNC_START);
   localparam logic [10:0] HS_OFF = 11'(H_SYNC_START + H_SYNC_LEN);
   localparam logic [10:0] VS_ON  = 11'(V_SYNC_START);
   localparam logic [10:0] VS_OFF = 11'(V_SYNC_START + V_SYNC_LEN);

   typedef enum logic [1:0] {HUNT, H_ALIGN, V_WAIT, LOCKED} state_t;

   state_t      state;
   logic        hs_p0, vs_p0;
   logic        hs_a, vs_a;
   logic        hs_rise, hs_fall, vs_rise, vs_fall;
   logic [10:0] x_nxt, y_nxt;
   logic        bad_h, bad_v, bad_b, fail;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign hs_a    = (hsync_in == SYNC_POL);
   assign vs_a    = (vsync_in == SYNC_POL);
   assign hs_rise = hs_a & ~hs_p0;
   assign hs_fall = ~hs_a & hs_p0;
   assign vs_rise = vs_a & ~vs_p0;
   assign vs_fall = ~vs_a & vs_p0;

   assign x_nxt = (x == H_LAST) ? 11'd0 : x + 11'd1;
   assign y_nxt = (x != H_LAST) ? y : ((y == V_LAST) ? 11'd0 : y + 11'd1);

   // Sync edges are judged against where the counters are about to land, since x/y lag by one clock.
   assign bad_h = (hs_rise && x_nxt != HS_ON) || (hs_fall && x_nxt != HS_OFF);
   assign bad_v = (vs_rise && (x_nxt != 11'd0 || y_nxt != VS_ON)) ||
                  (vs_fall && (x_nxt != 11'd0 || y_nxt != VS_OFF));
   assign bad_b = de != ((x < H_ACT) && (y < V_ACT));
   assign fail  = (state == LOCKED) && (bad_h || bad_v || bad_b);

   // Stage p0: sample inputs, advance position and lock state
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= HUNT;
         x           <= '0;
         y           <= '0;
         de          <= 1'b0;
         locked      <= 1'b0;
         frame_start <= 1'b0;
         err_hsync   <= 1'b0;
         err_vsync   <= 1'b0;
         err_blank   <= 1'b0;
         err_count   <= '0;
         hs_p0       <= 1'b0;
         vs_p0       <= 1'b0;
      end else begin
         hs_p0       <= hs_a;
         vs_p0       <= vs_a;
         de          <= ~hblnk_in & ~vblnk_in;
         locked      <= 1'b0;
         frame_start <= 1'b0;
         err_hsync   <= 1'b0;
         err_vsync   <= 1'b0;
         err_blank   <= 1'b0;
         case (state)
            HUNT: begin
               x <= '0;
               y <= '0;
               if (hs_rise) begin
                  x     <= HS_ON;
                  state <= H_ALIGN;
               end
            end
            H_ALIGN: begin
               x <= hs_rise ? HS_ON : x_nxt;
               y <= '0;
               if (hs_rise && x_nxt == HS_ON) state <= V_WAIT;
            end
            V_WAIT: begin
               x <= x_nxt;
               y <= '0;
               if (vs_rise) begin
                  if (x_nxt == 11'd0) begin
                     y      <= VS_ON;
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end else begin
                     x     <= '0;
                     state <= HUNT;
                  end
               end
            end
            LOCKED: begin
               if (fail) begin
                  err_hsync <= bad_h;
                  err_vsync <= bad_v;
                  err_blank <= bad_b;
                  err_count <= sat_inc(err_count);
                  x         <= '0;
                  y         <= '0;
                  state     <= HUNT;
               end else begin
                  x           <= x_nxt;
                  y           <= y_nxt;
                  locked      <= 1'b1;
                  frame_start <= (x_nxt == 11'd0) && (y_nxt == 11'd0);
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced 20x10 raster: directed scenarios plus a
// cycle-by-cycle behavioural model of the recovered position, lock and error outputs.
module tb_vga_sync_decoder;

   localparam int HT  = 20;
   localparam int HA  = 12;
   localparam int HSS = 14;
   localparam int HSL = 3;
   localparam int VT  = 10;
   localparam int VA  = 6;
   localparam int VSS = 7;
   localparam int VSL = 2;
   localparam int FR  = HT * VT;
   localparam bit POL = 1'b1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hsync_in = ~POL, vsync_in = ~POL, hblnk_in = 1'b1, vblnk_in = 1'b1;
   logic [10:0] x, y;
   logic        de, locked, frame_start, err_hsync, err_vsync, err_blank;
   logic [7:0]  err_count;

   vga_sync_decoder #(
      .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
      .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .SYNC_POL(POL)
   ) dut (
      .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .x(x), .y(y), .de(de), .locked(locked),
      .frame_start(frame_start), .err_hsync(err_hsync), .err_vsync(err_vsync),
      .err_blank(err_blank), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- behavioural model ----------------
   localparam int M_HUNT = 0, M_HALIGN = 1, M_VWAIT = 2, M_LOCKED = 3;
   int m_mode, mx, my, mcnt;
   bit mde, mlk, mfs, meh, mev, meb, mphs, mpvs;
   bit mvalid = 1'b0;

   task automatic model_step();
      bit hs_a, vs_a, hr, hf, vr, vf, bh, bv, bb;
      int nx, ny;
      if (rst) begin
         m_mode = M_HUNT; mx = 0; my = 0; mcnt = 0;
         mde = 0; mlk = 0; mfs = 0; meh = 0; mev = 0; meb = 0; mphs = 0; mpvs = 0;
         mvalid = 1'b1;
      end else if (mvalid) begin
         hs_a = (hsync_in === POL);
         vs_a = (vsync_in === POL);
         hr = hs_a && !mphs;  hf = !hs_a && mphs;
         vr = vs_a && !mpvs;  vf = !vs_a && mpvs;
         nx = (mx + 1) % HT;
         ny = (mx == HT - 1) ? (my + 1) % VT : my;
         bh = 0; bv = 0; bb = 0; mfs = 0;
         case (m_mode)
            M_HUNT: if (hr) begin mx = HSS; m_mode = M_HALIGN; end
            M_HALIGN: begin
               if (hr && nx == HSS) m_mode = M_VWAIT;
               mx = hr ? HSS : nx;
            end
            M_VWAIT: begin
               if (vr && nx == 0) begin mx = 0; my = VSS; m_mode = M_LOCKED; end
               else if (vr) begin mx = 0; m_mode = M_HUNT; end
               else mx = nx;
            end
            default: begin
               bh = (hr && nx != HSS) || (hf && nx != HSS + HSL);
               bv = (vr && !(nx == 0 && ny == VSS)) || (vf && !(nx == 0 && ny == VSS + VSL));
               bb = (mde != (mx < HA && my < VA));
               if (bh || bv || bb) begin m_mode = M_HUNT; mx = 0; my = 0; end
               else begin mfs = (nx == 0 && ny == 0); mx = nx; my = ny; end
            end
         endcase
         meh = bh; mev = bv; meb = bb;
         if ((bh || bv || bb) && mcnt < 255) mcnt++;
         mde = (hblnk_in === 1'b0) && (vblnk_in === 1'b0);
         mphs = hs_a; mpvs = vs_a;
         mlk = (m_mode == M_LOCKED);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (mvalid) begin
         checks++;
         if (x !== 11'(mx) || y !== 11'(my) || de !== mde || locked !== mlk ||
             frame_start !== mfs || err_hsync !== meh || err_vsync !== mev ||
             err_blank !== meb || err_count !== 8'(mcnt)) begin
            errors++;
            $display("FAIL model t=%0t got x=%0d y=%0d de=%b lk=%b fs=%b eh=%b ev=%b eb=%b cnt=%0d need x=%0d y=%0d de=%b lk=%b fs=%b eh=%b ev=%b eb=%b cnt=%0d",
                     $time, x, y, de, locked, frame_start, err_hsync, err_vsync, err_blank, err_count,
                     mx, my, mde, mlk, mfs, meh, mev, meb, mcnt);
         end
      end
   end

   // ---------------- stimulus ----------------
   int sh = 0, sv = 0, lh = 0, lv = 0, cyc = 0;
   bit arm_hs_delay = 0, arm_vs_short = 0, arm_hb = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_raw(input logic hs, input logic vs, input logic hb, input logic vb);
      hsync_in = POL ? hs : ~hs;
      vsync_in = POL ? vs : ~vs;
      hblnk_in = hb;
      vblnk_in = vb;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step_src();
      logic hs, vs, hb, vb;
      hs = (sh >= HSS && sh < HSS + HSL);
      if (arm_hs_delay && sh == HSS) begin hs = 1'b0; arm_hs_delay = 0; end
      vs = (sv >= VSS && sv < VSS + VSL - (arm_vs_short ? 1 : 0));
      hb = (sh >= HA);
      vb = (sv >= VA);
      if (arm_hb && sv == 1 && sh == HSS + 1) begin hb = 1'b0; arm_hb = 0; end
      lh = sh; lv = sv;
      drive_raw(hs, vs, hb, vb);
      sh++;
      if (sh == HT) begin sh = 0; sv = (sv + 1) % VT; end
   endtask

   function automatic bit sel_sig(input int sel);
      case (sel)
         0:       return locked;
         1:       return err_hsync;
         2:       return err_vsync;
         default: return err_blank;
      endcase
   endfunction

   task automatic run_until(input int sel, input int budget, input string name, output int n);
      bit hit;
      hit = 0;
      n = 0;
      while (!hit && n < budget) begin
         step_src();
         n++;
         hit = sel_sig(sel);
      end
      if (!hit) begin
         checks++;
         errors++;
         $display("FAIL %s: no event within %0d clocks", name, budget);
      end
   endtask

   initial begin
      int n, fs_n, last;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_x", int'(x), 0);
      chk("reset_locked", int'(locked), 0);
      chk("reset_de", int'(de), 0);
      chk("reset_err_count", int'(err_count), 0);
      rst = 1'b0;

      // First lock: hsync rise line 0, realign line 1, vsync rise at line VSS x=0.
      run_until(0, 2 * FR, "initial_lock", n);
      chk("lock_latency", n, VSS * HT + 1);
      chk("lock_y", int'(y), VSS);

      fs_n = 0; last = 0;
      for (int i = 0; i < 3 * FR; i++) begin
         step_src();
         checks++;
         if (int'(x) != lh || int'(y) != lv) begin
            errors++;
            $display("FAIL track: got x=%0d y=%0d, expected x=%0d y=%0d", x, y, lh, lv);
         end
         if (frame_start) begin
            if (fs_n > 0) chk("frame_spacing", cyc - last, FR);
            last = cyc;
            fs_n++;
         end
      end
      chk("frame_start_count", fs_n, 3);
      chk("no_err_3_frames", int'(err_count), 0);

      arm_hs_delay = 1;
      run_until(1, 2 * HT, "err_hsync", n);
      chk("hsync_locked_drop", int'(locked), 0);
      chk("hsync_err_count", int'(err_count), 1);
      step_src();
      chk("hsync_pulse_width", int'(err_hsync), 0);
      run_until(0, 2 * FR, "relock_after_hsync", n);
      chk("relock_hsync", int'(locked), 1);

      arm_vs_short = 1;
      run_until(2, 2 * FR, "err_vsync", n);
      arm_vs_short = 0;
      chk("vsync_locked_drop", int'(locked), 0);
      chk("vsync_err_count", int'(err_count), 2);
      run_until(0, 2 * FR, "relock_after_vsync", n);

      arm_hb = 1;
      run_until(3, 2 * FR, "err_blank", n);
      chk("blank_locked_drop", int'(locked), 0);
      chk("blank_err_count", int'(err_count), 3);
      run_until(0, 2 * FR, "relock_after_blank", n);

      repeat (50) step_src();
      rst = 1'b1;
      step_src();
      chk("midrst_xy", int'({x, y}), 0);
      chk("midrst_flags", int'({de, locked, frame_start, err_hsync, err_vsync, err_blank}), 0);
      chk("midrst_err_count", int'(err_count), 0);
      step_src();
      rst = 1'b0;
      run_until(0, 2 * FR, "relock_after_rst", n);
      chk("relock_rst", int'(locked), 1);

      // Fast raw lock/unlock loop: each pass locks, then drops vsync one pixel early.
      rst = 1'b1;
      drive_raw(1'b0, 1'b0, 1'b1, 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 300; i++) begin
         drive_raw(1'b1, 1'b0, 1'b1, 1'b1);
         repeat (HT - 1) drive_raw(1'b0, 1'b0, 1'b1, 1'b1);
         drive_raw(1'b1, 1'b0, 1'b1, 1'b1);
         repeat (HT - HSS - 1) drive_raw(1'b0, 1'b0, 1'b1, 1'b1);
         drive_raw(1'b0, 1'b1, 1'b1, 1'b1);
         if (i == 0) chk("raw_lock", int'(locked), 1);
         drive_raw(1'b0, 1'b0, 1'b1, 1'b1);
         if (i == 0) chk("raw_err_vsync", int'(err_vsync), 1);
         if (i == 99) chk("err_count_100", int'(err_count), 100);
      end
      chk("err_count_saturated", int'(err_count), 255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
